// File: rtl/maxpool_pkg.sv
// Shared types and constants for the max-pooling sequencer.
// Optional build macro: MAXPOOL_RELU_EN (fused ReLU on the window maximum).
package maxpool_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_WIN_W  = 8;
    localparam int DEF_CH_W   = 16;

    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int          FP16_SIGN_BIT = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/maxpool_seq.sv
// Max-pooling sequencer: streams window elements, drives an external
// one-shot FP16 comparator to keep a running maximum, and emits one
// maximum per window for cfg_chan windows per job.
// Optional build macro: MAXPOOL_RELU_EN -- when defined, negative maxima
// are clamped to +0 on the output.
module maxpool_seq
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN_W  = DEF_WIN_W,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIN_W-1:0]  cfg_win,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] cmp_new,
    output logic [DATA_W-1:0] cmp_ori,
    output logic              cmp_req,
    input  logic              cmp_rdy,
    input  logic              cmp_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

`ifdef MAXPOOL_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    // Output formatting of a window maximum (optional ReLU clamp).
    function automatic logic [DATA_W-1:0] out_fmt(input logic [DATA_W-1:0] v);
        out_fmt = (RELU_EN && v[FP16_SIGN_BIT]) ? DATA_W'(FP16_ZERO) : v;
    endfunction

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [WIN_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic [CH_W-1:0]     win_cnt_q, win_cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   cand_q, cand_d;
    logic [DATA_W-1:0]   cmp_new_q, cmp_new_d;
    logic [DATA_W-1:0]   cmp_ori_q, cmp_ori_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                in_ready_q, in_ready_d;
    logic                cmp_req_q, cmp_req_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                in_acc_s;

    // An element is taken only when the registered ready is being presented.
    assign in_acc_s = in_valid && in_ready_q;

    // Next-state, datapath and registered-output decode for the sequencer.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        chan_d     = chan_q;
        elem_cnt_d = elem_cnt_q;
        win_cnt_d  = win_cnt_q;
        max_d      = max_q;
        cand_d     = cand_q;
        cmp_new_d  = cmp_new_q;
        cmp_ori_d  = cmp_ori_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero window size behaves as a single-element window.
                    win_d      = (cfg_win == '0) ? WIN_W'(1'b1) : cfg_win;
                    chan_d     = cfg_chan;
                    win_cnt_d  = '0;
                    elem_cnt_d = '0;
                    state_d    = (cfg_chan == '0) ? DONE : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (in_acc_s) begin
                    max_d      = in_data;
                    elem_cnt_d = WIN_W'(1'b1);
                    // Single-element windows skip the comparator entirely.
                    state_d    = (win_q == WIN_W'(1'b1)) ? OUT : FETCH;
                end else begin
                    state_d = LOAD;
                end
            end
            FETCH: begin
                if (in_acc_s) begin
                    cand_d     = in_data;
                    cmp_new_d  = in_data;
                    cmp_ori_d  = max_q;
                    elem_cnt_d = elem_cnt_q + WIN_W'(1'b1);
                    state_d    = ISSUE;
                end else begin
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cmp_rdy) begin
                    // Ties keep the earlier value, so only a strict win replaces it.
                    max_d   = cmp_result ? cand_q : max_q;
                    state_d = (elem_cnt_q == win_q) ? OUT : FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            OUT: begin
                if (out_ready && out_valid_q) begin
                    win_cnt_d = win_cnt_q + CH_W'(1'b1);
                    state_d   = (win_cnt_d == chan_q) ? DONE : LOAD;
                end else begin
                    state_d = OUT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake/status outputs are registered copies of the next state.
        in_ready_d  = (state_d == LOAD) || (state_d == FETCH);
        cmp_req_d   = (state_d == ISSUE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);

        // The result register captures the final maximum as OUT is entered.
        if ((state_d == OUT) && (state_q != OUT)) begin
            out_data_d = out_fmt(max_d);
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State, counters, datapath and output registers; reset aborts any job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            chan_q      <= '0;
            elem_cnt_q  <= '0;
            win_cnt_q   <= '0;
            max_q       <= '0;
            cand_q      <= '0;
            cmp_new_q   <= '0;
            cmp_ori_q   <= '0;
            out_data_q  <= DATA_W'(FP16_ZERO);
            in_ready_q  <= 1'b0;
            cmp_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            chan_q      <= chan_d;
            elem_cnt_q  <= elem_cnt_d;
            win_cnt_q   <= win_cnt_d;
            max_q       <= max_d;
            cand_q      <= cand_d;
            cmp_new_q   <= cmp_new_d;
            cmp_ori_q   <= cmp_ori_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            cmp_req_q   <= cmp_req_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cmp_new   = cmp_new_q;
    assign cmp_ori   = cmp_ori_q;
    assign cmp_req   = cmp_req_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
